// File: rtl/aes_pkg.sv
// Shared AES constants, column payload type and FSM encoding for the MixColumns datapath.
package aes_pkg;

    localparam int unsigned AES_STATE_W  = 128;
    localparam int unsigned AES_COL_W    = 32;
    localparam int unsigned AES_NUM_COLS = AES_STATE_W / AES_COL_W;
    localparam logic [7:0]  GF_POLY      = 8'h1b;

    // One state column; r0 occupies the most significant byte.
    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
    } aes_col_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    // Multiply by 02 in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward MixColumns of a single 32-bit state column.
module mix_column_word
    import aes_pkg::*;
(
    input  aes_col_t col,
    output aes_col_t mixed_c
);

    // Rows of the circulant matrix [02 03 01 01]; 03*x = xtime(x)^x.
    always_comb begin
        mixed_c.r0 = xtime(col.r0) ^ xtime(col.r1) ^ col.r1 ^ col.r2 ^ col.r3;
        mixed_c.r1 = col.r0 ^ xtime(col.r1) ^ xtime(col.r2) ^ col.r2 ^ col.r3;
        mixed_c.r2 = col.r0 ^ col.r1 ^ xtime(col.r2) ^ xtime(col.r3) ^ col.r3;
        mixed_c.r3 = xtime(col.r0) ^ col.r0 ^ col.r1 ^ col.r2 ^ xtime(col.r3);
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: captures a block, transforms COLS_PER_CYCLE columns per
// cycle in place (column 3 first), then holds the result until the consumer takes it.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned     CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_NUM_COLS - COLS_PER_CYCLE);

    state_t                 state;
    state_t                 state_n;
    logic [AES_STATE_W-1:0] work;
    logic [AES_STATE_W-1:0] work_n;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic                   in_ready_n;
    logic                   out_valid_n;
    logic                   busy_n;

    logic [CNT_W-1:0] col_idx [COLS_PER_CYCLE];
    aes_col_t         col_in  [COLS_PER_CYCLE];
    aes_col_t         col_out [COLS_PER_CYCLE];

    // Lane k handles column 3-cnt-k of the working register.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign col_idx[k] = CNT_W'(AES_NUM_COLS - 1 - k) - cnt;
        assign col_in[k]  = work[int'(col_idx[k]) * AES_COL_W +: AES_COL_W];

        mix_column_word u_mix (
            .col     (col_in[k]),
            .mixed_c (col_out[k])
        );
    end

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_n  = in_state;
                    cnt_n   = '0;
                    state_n = CALC;
                end
            end
            CALC: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_n[int'(col_idx[k]) * AES_COL_W +: AES_COL_W] = col_out[k];
                end
                cnt_n = cnt + CNT_STEP;
                if (cnt == CNT_LAST) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // out_valid trails HOLD entry by one cycle and drops with the handshake edge.
        in_ready_n  = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
        out_valid_n = (state == HOLD) && (state_n == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            work      <= work_n;
            cnt       <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
        end
    end

    assign out_state = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: known vectors, latency, back-pressure,
// reset abort and a randomized scoreboard run against a software MixColumns model.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         busy;

    logic         in_valid_x4 = 1'b0;
    logic         in_ready_x4;
    logic [127:0] in_state_x4 = '0;
    logic         out_valid_x4;
    logic         out_ready_x4 = 1'b0;
    logic [127:0] out_state_x4;
    logic         busy_x4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut_x4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_x4),
        .in_ready  (in_ready_x4),
        .in_state  (in_state_x4),
        .out_valid (out_valid_x4),
        .out_ready (out_ready_x4),
        .out_state (out_state_x4),
        .busy      (busy_x4)
    );

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c*32+24 +: 8];
            a1 = s[c*32+16 +: 8];
            a2 = s[c*32+8  +: 8];
            a3 = s[c*32    +: 8];
            r[c*32+24 +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[c*32+16 +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[c*32+8  +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[c*32    +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One block through the COLS_PER_CYCLE=1 instance with out_ready held high.
    task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input int lat);
        int n;
        in_valid  = 1'b1;
        in_state  = din;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        in_state = ~din;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", 128'(n), 128'(lat));
        chk("out_state", out_state, exp);
        chk("busy_in_hold", 128'(busy), 128'(1));
        step();
        chk("out_valid_one_cycle", 128'(out_valid), 128'(0));
        chk("in_ready_after_done", 128'(in_ready), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic [127:0] blk_a, blk_b, blk_c;
        logic [127:0] exp_q[$];
        logic [127:0] exp_v;
        int n, hits, sent, recv, budget;

        vecs[0] = '{128'hdb135345_f20a225c_01010101_2d26314c, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8};
        vecs[1] = '{128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6};
        vecs[2] = '{128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6};
        vecs[3] = '{128'hc6c6c6c6_d4d4d4d5_2d26314c_db135345, 128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_8e4da1bc};

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_out_state", out_state, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].din, vecs[i].dout, 5);
        end

        // Back-pressure: result held, new block refused until the handshake.
        blk_a = rand128();
        blk_b = rand128();
        in_valid  = 1'b1;
        in_state  = blk_a;
        out_ready = 1'b0;
        chk("hold_in_ready_idle", 128'(in_ready), 128'(1));
        step();
        in_state = blk_b;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("hold_out_valid", 128'(out_valid), 128'(1));
            chk("hold_out_state", out_state, mix_model(blk_a));
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_hs_out_valid", 128'(out_valid), 128'(0));
        chk("after_hs_in_ready", 128'(in_ready), 128'(1));
        step();
        chk("new_block_busy", 128'(busy), 128'(1));
        chk("new_block_in_ready", 128'(in_ready), 128'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("new_block_result", out_state, mix_model(blk_b));
        step();

        // Reset in the middle of CALC, between clock edges.
        in_valid  = 1'b1;
        in_state  = rand128();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_out_state", out_state, 128'h0);
        #1 rst = 1'b0;
        blk_c = rand128();
        in_valid = 1'b1;
        in_state = blk_c;
        step();
        chk("first_edge_accept", 128'(busy), 128'(1));
        in_valid = 1'b0;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                hits++;
                chk("post_abort_result", out_state, mix_model(blk_c));
            end
            step();
        end
        chk("post_abort_out_count", 128'(hits), 128'(1));

        // Randomized traffic against the scoreboard.
        sent = 0;
        recv = 0;
        while (sent < 1000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_state  = rand128();
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(mix_model(in_state));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rand_duplicate: output with empty scoreboard, got %h", out_state);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rand_result", out_state, exp_v);
                end
                recv++;
            end
            step();
        end
        in_valid = 1'b0;
        budget = 0;
        while (recv < sent && budget < 200) begin
            out_ready = ($urandom_range(0, 1) != 0);
            if (out_valid && out_ready) begin
                exp_v = exp_q.pop_front();
                chk("rand_result", out_state, exp_v);
                recv++;
            end
            step();
            budget++;
        end
        chk("rand_received", 128'(recv), 128'(sent));
        chk("rand_queue_empty", 128'(exp_q.size()), 128'(0));
        out_ready = 1'b0;

        // Four columns per cycle: same result, shorter latency.
        in_valid_x4  = 1'b1;
        in_state_x4  = vecs[0].din;
        out_ready_x4 = 1'b1;
        chk("x4_in_ready", 128'(in_ready_x4), 128'(1));
        step();
        in_valid_x4 = 1'b0;
        in_state_x4 = '0;
        n = 0;
        while (!out_valid_x4 && n < 20) begin
            step();
            n++;
        end
        chk("x4_latency", 128'(n), 128'(2));
        chk("x4_out_state", out_state_x4, vecs[0].dout);
        step();
        chk("x4_out_valid_one_cycle", 128'(out_valid_x4), 128'(0));
        chk("x4_busy_done", 128'(busy_x4), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, setting the columns transformed per CALC cycle; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_state holds a valid block.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept input.
REQ-006 The block SHALL have port in_state, input, 128 bits: the AES state; column c is in_state[c*32+:32], row 0 at bits c*32+24.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_state holds a valid result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_state.
REQ-009 The block SHALL have port out_state, output, 128 bits: the forward MixColumns result, with the same column and byte layout as in_state.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 Each column SHALL be multiplied in GF(2^8), polynomial 0x11b, by the matrix rows [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
- xtime(x) is x<<1, XOR 0x1b when x[7]=1.
- 03*x is xtime(x)^x.
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and HOLD.
REQ-013 In IDLE, in_ready SHALL be 1, and in_valid&in_ready SHALL capture in_state into the working register, clear the column counter and move to CALC.
REQ-014 In CALC, each cycle SHALL transform COLS_PER_CYCLE columns in place.
- Order is column 3 (bits 127:96) first, down to column 0.
- The counter advances by COLS_PER_CYCLE per cycle.
REQ-015 After the cycle that transforms column 0, the FSM SHALL enter HOLD.
- CALC lasts 4/COLS_PER_CYCLE cycles.
- out_valid rises 4/COLS_PER_CYCLE+1 cycles after the accept edge.
REQ-016 In HOLD, out_valid SHALL be 1 and out_state SHALL stay stable until out_valid&out_ready.
REQ-017 On out_valid&out_ready, the FSM SHALL return to IDLE on the next edge.
- No new input is accepted in that same cycle; in_ready is 0 in HOLD.
REQ-018 in_ready SHALL be 0 in CALC and HOLD, and in_state SHALL be ignored there; no input is lost because the handshake is not completed.
REQ-019 out_state SHALL be driven only from the working register; it is valid only when out_valid=1, and its value otherwise is unspecified.
REQ-020 The counter SHALL be 2 bits wide and wrap from 3 to 0 without side effect; only the FSM transition ends CALC.
REQ-021 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-022 Asserting rst SHALL immediately force: state IDLE, in_ready=1, out_valid=0, busy=0, counter=0, working register=0.
REQ-023 rst asserted during CALC or HOLD SHALL abort the block; no output handshake is produced for it.
REQ-024 After rst deasserts, the first rising clk edge SHALL already accept a presented input.

Structure
REQ-025 Package aes_pkg SHALL hold:
- the AES_STATE_W=128 and AES_COL_W=32 constants;
- the GF_POLY=8'h1b constant;
- the state enum {IDLE, CALC, HOLD}.
REQ-026 Sub-module mix_column_word SHALL implement the combinational forward transform of one 32-bit column.
- mix_columns_seq instantiates COLS_PER_CYCLE copies of it.

Verification
REQ-027 Scenario: in_state=128'hdb135345_f20a225c_01010101_2d26314c, COLS_PER_CYCLE=1, out_ready=1.
- out_state=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8.
- out_valid is high for exactly 1 cycle.
- out_valid rises 5 cycles after the accept edge.
REQ-028 Scenario: the same vector with COLS_PER_CYCLE=4.
- out_valid rises 2 cycles after the accept edge.
- The result is identical to REQ-027.
REQ-029 Scenario: in_state column values c6c6c6c6 and d4d4d4d5.
- c6c6c6c6 -> c6c6c6c6.
- d4d4d4d5 -> d5d5d7d6.
REQ-030 Scenario: out_ready held 0 for 10 cycles.
- out_valid stays 1 and out_state is stable.
- in_ready stays 0 while in_valid=1 with a new block.
- After out_ready pulses, the new block is accepted exactly one cycle later.
REQ-031 Scenario: rst pulsed mid-CALC, between clock edges.
- Outputs reset immediately: out_valid=0, in_ready=1, busy=0.
- No out_valid pulse is ever produced for the aborted block.
REQ-032 Scenario: 1000 random blocks with random in_valid and out_ready gaps, compared against a software MixColumns model.
- No mismatch, no drop, no duplicate.
